// File: rtl/mac_pkg.sv
// Shared constants for the MAC-team pipeline stages: default accumulator/counter
// widths and the operand/product widths of the 8x8 multiplier datapath.
package mac_pkg;
   localparam int unsigned MAC_ACC_W  = 24;
   localparam int unsigned MAC_CNT_W  = 16;
   localparam int unsigned MAC_OP_W   = 8;
   localparam int unsigned MAC_PROD_W = 16;
endpackage

// File: rtl/mac_accumulate_stage_if.sv
// Operand-in and result-out handshake bundle for mac_accumulate_stage.
// master = producer/consumer side, slave = the MAC stage.
interface mac_accumulate_stage_if #(
   parameter int unsigned ACC_W = mac_pkg::MAC_ACC_W,
   parameter int unsigned CNT_W = mac_pkg::MAC_CNT_W
);
   logic                         in_valid;
   logic                         in_ready;
   logic [mac_pkg::MAC_OP_W-1:0] in_a;
   logic [mac_pkg::MAC_OP_W-1:0] in_b;
   logic                         in_last;
   logic                         out_valid;
   logic                         out_ready;
   logic [ACC_W-1:0]             out_acc;
   logic [CNT_W-1:0]             out_cnt;
   logic                         out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_cnt, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_cnt, out_ovf
   );
endinterface

// File: rtl/dadda_8_8_mult.sv
// Combinational 8x8 unsigned multiplier; partial products are summed in
// shift-add form and reduced to a compressor tree by synthesis.
module dadda_8_8_mult (
   input  logic [mac_pkg::MAC_OP_W-1:0]   a,
   input  logic [mac_pkg::MAC_OP_W-1:0]   b,
   output logic [mac_pkg::MAC_PROD_W-1:0] p
);
   import mac_pkg::*;

   always_comb begin
      p = '0;
      for (int unsigned i = 0; i < MAC_OP_W; i++) begin
         if (b[i]) p = p + (MAC_PROD_W'(a) << i);
      end
   end
endmodule

// File: rtl/mac_accumulate_stage.sv
// Two-stage multiply-accumulate: registered product, then a wide sticky-overflow
// accumulator that hands each completed group to a one-entry result buffer.
module mac_accumulate_stage #(
   parameter int unsigned ACC_W = mac_pkg::MAC_ACC_W,
   parameter int unsigned CNT_W = mac_pkg::MAC_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mac_accumulate_stage_if.slave  bus
);
   import mac_pkg::*;

   logic                  p_valid_q, p_valid_d;
   logic                  p_last_q, p_last_d;
   logic [MAC_PROD_W-1:0] p_prod_q, p_prod_d;
   logic [MAC_PROD_W-1:0] mult_p;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic                  out_valid_q, out_valid_d;
   logic [ACC_W-1:0]      out_acc_q, out_acc_d;
   logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
   logic                  out_ovf_q, out_ovf_d;
   logic [ACC_W:0]        sum;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  ovf_inc;
   logic                  consume;
   logic                  in_fire;

   dadda_8_8_mult u_mult (
      .a (bus.in_a),
      .b (bus.in_b),
      .p (mult_p)
   );

   // Only a last product needs the result buffer, so only it can be blocked.
   assign consume = p_valid_q && !(p_last_q && out_valid_q && !bus.out_ready);
   assign in_fire = bus.in_valid && bus.in_ready;

   assign bus.in_ready  = !p_valid_q || consume;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.out_ovf   = out_ovf_q;

   always_comb begin
      sum     = {1'b0, acc_q} + (ACC_W + 1)'(p_prod_q);
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      ovf_inc = ovf_q | sum[ACC_W];

      p_valid_d   = p_valid_q;
      p_last_d    = p_last_q;
      p_prod_d    = p_prod_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_acc_d   = out_acc_q;
      out_cnt_d   = out_cnt_q;
      out_ovf_d   = out_ovf_q;

      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

      if (in_fire) begin
         p_valid_d = 1'b1;
         p_last_d  = bus.in_last;
         p_prod_d  = mult_p;
      end else if (consume) begin
         p_valid_d = 1'b0;
      end

      if (consume) begin
         if (p_last_q) begin
            out_valid_d = 1'b1;
            out_acc_d   = sum[ACC_W-1:0];
            out_cnt_d   = cnt_inc;
            out_ovf_d   = ovf_inc;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
         end else begin
            acc_d = sum[ACC_W-1:0];
            cnt_d = cnt_inc;
            ovf_d = ovf_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_valid_q   <= 1'b0;
         p_last_q    <= 1'b0;
         p_prod_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_cnt_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         p_valid_q   <= p_valid_d;
         p_last_q    <= p_last_d;
         p_prod_q    <= p_prod_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_cnt_q   <= out_cnt_d;
         out_ovf_q   <= out_ovf_d;
      end
   end
endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Directed and randomised checks of mac_accumulate_stage against a group-sum model.
module tb_mac_accumulate_stage;
   localparam int unsigned ACC_W    = 24;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned N_GROUPS = 300;
   localparam int unsigned BUDGET   = 60000;
   localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;
   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

   typedef struct {
      logic [ACC_W-1:0] acc;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
   } res_t;

   logic clk;
   logic rst_n;
   int unsigned checks;
   int unsigned errors;

   mac_accumulate_stage_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   mac_accumulate_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic last);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_last  = last;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic v, input longint unsigned acc,
                            input longint unsigned cnt, input logic ovf);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
      check({tag, "_acc"}, 64'(bus.out_acc), acc);
      check({tag, "_cnt"}, 64'(bus.out_cnt), cnt);
      check({tag, "_ovf"}, 64'(bus.out_ovf), 64'(ovf));
   endtask

   function automatic int unsigned group_len();
      return ($urandom_range(0, 15) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 8);
   endfunction

   res_t            exp_q[$];
   res_t            r;
   longint unsigned m_total;
   longint unsigned m_n;
   int unsigned     groups_sent, groups_got, beats_left, cyc;
   logic            pending, fire_in, fire_out;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      #12;
      check_out("rst", 1'b0, 0, 0, 1'b0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Single beat: result visible one edge after the accept edge, for one cycle
      bus.out_ready = 1'b1;
      drive(8'd255, 8'd255, 1'b1);
      @(negedge clk);
      check("single_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      idle();
      check("single_early", 64'(bus.out_valid), 64'd0);
      tick();
      check_out("single", 1'b1, 65025, 1, 1'b0);
      tick();
      check("single_drop", 64'(bus.out_valid), 64'd0);

      // Four back-to-back beats
      drive(8'd3, 8'd5, 1'b0);
      @(negedge clk); check("four_rdy0", 64'(bus.in_ready), 64'd1); tick();
      drive(8'd7, 8'd11, 1'b0);
      @(negedge clk); check("four_rdy1", 64'(bus.in_ready), 64'd1); tick();
      drive(8'd0, 8'd200, 1'b0);
      @(negedge clk); check("four_rdy2", 64'(bus.in_ready), 64'd1); tick();
      drive(8'd128, 8'd2, 1'b1);
      @(negedge clk); check("four_rdy3", 64'(bus.in_ready), 64'd1); tick();
      idle();
      tick();
      check_out("four", 1'b1, 348, 4, 1'b0);
      tick();

      // Backpressure across two groups
      bus.out_ready = 1'b0;
      drive(8'd10, 8'd10, 1'b1);
      tick();
      idle();
      tick();
      check_out("bp_first", 1'b1, 100, 1, 1'b0);
      drive(8'd2, 8'd2, 1'b0);
      @(negedge clk); check("bp_rdy_a", 64'(bus.in_ready), 64'd1); tick();
      drive(8'd4, 8'd4, 1'b1);
      @(negedge clk); check("bp_rdy_b", 64'(bus.in_ready), 64'd1); tick();
      idle();
      @(negedge clk);
      check("bp_stall_rdy", 64'(bus.in_ready), 64'd0);
      tick();
      check_out("bp_hold", 1'b1, 100, 1, 1'b0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_rdy", 64'(bus.in_ready), 64'd1);
      tick();
      check_out("bp_second", 1'b1, 20, 2, 1'b0);
      tick();
      check("bp_drain", 64'(bus.out_valid), 64'd0);

      // Overflow: 259 x 65025 wraps past 2^24
      for (int i = 0; i < 259; i++) begin
         drive(8'd255, 8'd255, i == 258);
         tick();
      end
      idle();
      tick();
      check_out("ovf", 1'b1, 64259, 259, 1'b1);
      drive(8'd1, 8'd1, 1'b1);
      tick();
      idle();
      tick();
      check_out("ovf_next", 1'b1, 1, 1, 1'b0);
      tick();

      // Reset in the middle of a group
      drive(8'd9, 8'd9, 1'b0);
      tick();
      tick();
      idle();
      #2 rst_n = 1'b0;
      #1 check_out("midrst", 1'b0, 0, 0, 1'b0);
      check("midrst_rdy", 64'(bus.in_ready), 64'd1);
      #1 rst_n = 1'b1;
      tick();
      drive(8'd2, 8'd3, 1'b1);
      tick();
      idle();
      tick();
      check_out("midrst_after", 1'b1, 6, 1, 1'b0);
      tick();

      // Randomised groups with random valid/ready
      m_total = 0; m_n = 0;
      groups_sent = 0; groups_got = 0; beats_left = 0; cyc = 0;
      pending = 1'b0;
      while (groups_got < N_GROUPS && cyc < BUDGET) begin
         if (!pending) begin
            if (groups_sent < N_GROUPS && $urandom_range(0, 3) != 0) begin
               if (beats_left == 0) beats_left = group_len();
               drive(($urandom_range(0, 1) != 0) ? 8'd255 : 8'($urandom_range(0, 255)),
                     ($urandom_range(0, 1) != 0) ? 8'd255 : 8'($urandom_range(0, 255)),
                     beats_left == 1);
            end else begin
               idle();
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         fire_in  = bus.in_valid && bus.in_ready;
         fire_out = bus.out_valid && bus.out_ready;
         pending  = bus.in_valid && !bus.in_ready;
         if (fire_out) begin
            if (exp_q.size() == 0) begin
               check("rnd_unexpected", 64'(bus.out_acc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               r = exp_q.pop_front();
               check("rnd_acc", 64'(bus.out_acc), 64'(r.acc));
               check("rnd_cnt", 64'(bus.out_cnt), 64'(r.cnt));
               check("rnd_ovf", 64'(bus.out_ovf), 64'(r.ovf));
            end
            groups_got++;
         end
         if (fire_in) begin
            m_total += longint'(bus.in_a) * longint'(bus.in_b);
            m_n++;
            beats_left--;
            if (bus.in_last) begin
               r.acc = ACC_W'(m_total % ACC_MOD);
               r.cnt = CNT_W'((m_n > CNT_MAX) ? CNT_MAX : m_n);
               r.ovf = (m_total >= ACC_MOD);
               exp_q.push_back(r);
               m_total = 0;
               m_n = 0;
               groups_sent++;
            end
         end
         tick();
         cyc++;
      end
      idle();
      check("rnd_groups_done", 64'(groups_got), 64'(N_GROUPS));
      check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
